// File: rtl/exe_stage_pkg.sv
// Shared types for the execute stage: ALU opcodes, memory sizes, exception
// codes and the packed layouts of the ID->EX and EX->MEM pipeline buses.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  localparam logic [5:0] ECODE_ALE = 6'h09;

  // ID -> EX bus; src2 already carries the immediate where applicable
  typedef struct packed {
    alu_op_e     alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        st_or_ld;
    logic        mem_we;
    mem_size_e   mem_size;
    logic        ld_unsigned;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rkd;
    logic [31:0] pc;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic        ertn;
    logic        is_exc;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        addr_exc;
    logic [31:0] badv;
    logic        is_tlb_exc;
  } ds_to_es_t;

  // EX -> MEM bus, in the order the memory stage unpacks it
  typedef struct packed {
    logic        st_or_ld;
    logic        mem_we;
    mem_size_e   mem_size;
    logic        ld_unsigned;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic        ertn;
    logic        is_exc;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        addr_exc;
    logic [31:0] badv;
    logic [31:0] pc_to_era;
    logic        is_tlb_exc;
  } es_to_ms_t;

  localparam int DS_TO_ES_WD = $bits(ds_to_es_t);
  localparam int ES_TO_MS_WD = $bits(es_to_ms_t);

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational integer ALU used by the execute stage.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  alu_op_e     i_alu_op,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  output logic [31:0] o_result
);

  // Select the operation; shifts use only the low five bits of src2
  always_comb begin
    o_result = 32'h0;
    case (i_alu_op)
      ALU_ADD:  o_result = i_src1 + i_src2;
      ALU_SUB:  o_result = i_src1 - i_src2;
      ALU_SLT:  o_result = {31'h0, $signed(i_src1) < $signed(i_src2)};
      ALU_SLTU: o_result = {31'h0, i_src1 < i_src2};
      ALU_AND:  o_result = i_src1 & i_src2;
      ALU_OR:   o_result = i_src1 | i_src2;
      ALU_XOR:  o_result = i_src1 ^ i_src2;
      ALU_NOR:  o_result = ~(i_src1 | i_src2);
      ALU_SLL:  o_result = i_src1 << i_src2[4:0];
      ALU_SRL:  o_result = i_src1 >> i_src2[4:0];
      ALU_SRA:  o_result = 32'($signed(i_src1) >>> i_src2[4:0]);
      ALU_LUI:  o_result = i_src2;
      default:  o_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, data-sram request issue, alignment exceptions and
// the exception block that keeps memory quiet until the pipeline flushes.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DS_TO_ES_BUS_WD = DS_TO_ES_WD,
  parameter int ES_TO_MS_BUS_WD = ES_TO_MS_WD
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_ms_allowin,
  output logic                       o_es_allowin,
  input  logic                       i_ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] i_ds_to_es_bus,
  output logic                       o_es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] o_es_to_ms_bus,
  output logic [4:0]                 o_es_to_ds_dest,
  output logic [31:0]                o_es_to_ds_result,
  output logic                       o_es_to_ds_is_ld,
  input  logic                       i_flush,
  input  logic                       i_ms_is_exc,
  output logic                       o_data_sram_req,
  output logic                       o_data_sram_wr,
  output logic [1:0]                 o_data_sram_size,
  output logic [31:0]                o_data_sram_addr,
  output logic [3:0]                 o_data_sram_wstrb,
  output logic [31:0]                o_data_sram_wdata,
  input  logic                       i_data_sram_addr_ok
);

  logic                       r_es_valid;
  logic                       r_exc_block;
  logic [DS_TO_ES_BUS_WD-1:0] r_ds_bus;

  ds_to_es_t   w_ds;
  es_to_ms_t   w_ms_bus;
  logic [31:0] w_alu_result;
  logic        w_is_word;
  logic        w_is_half;
  logic        w_ale;
  logic        w_es_is_exc;
  logic        w_kill;
  logic        w_es_ready_go;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign w_ds = ds_to_es_t'(r_ds_bus);

  exe_stage_alu u_alu (
    .i_alu_op (w_ds.alu_op),
    .i_src1   (w_ds.src1),
    .i_src2   (w_ds.src2),
    .o_result (w_alu_result)
  );

  // Alignment check: words need addr[1:0]==0, halves need addr[0]==0
  assign w_is_word   = w_ds.st_or_ld && (w_ds.mem_size == SIZE_WORD);
  assign w_is_half   = w_ds.st_or_ld && (w_ds.mem_size == SIZE_HALF);
  assign w_ale       = (w_is_word && (w_alu_result[1:0] != 2'b00)) ||
                       (w_is_half && w_alu_result[0]);
  assign w_es_is_exc = w_ds.is_exc || w_ale;

  // Any pending or older exception, or a flush, suppresses the memory side effect
  assign w_kill = i_flush || i_ms_is_exc || r_exc_block || w_es_is_exc;

  // A request is only issued when ms can take the instruction in the same
  // cycle, so ms is always ready for the matching data_ok later
  assign o_data_sram_req = r_es_valid && w_ds.st_or_ld && !w_kill && i_ms_allowin;
  assign w_es_ready_go   = !w_ds.st_or_ld || w_kill ||
                           (o_data_sram_req && i_data_sram_addr_ok);

  assign o_es_allowin     = !r_es_valid || (w_es_ready_go && i_ms_allowin);
  assign o_es_to_ms_valid = r_es_valid && w_es_ready_go;

  // Valid bit: flush wins, otherwise take whatever ID offers when we can accept
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_es_valid <= 1'b0;
    end else if (i_flush) begin
      r_es_valid <= 1'b0;
    end else if (o_es_allowin) begin
      r_es_valid <= i_ds_to_es_valid;
    end
  end

  // Instruction register; held while waiting for addr_ok so request fields stay stable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ds_bus <= '0;
    end else if (i_ds_to_es_valid && o_es_allowin && !i_flush) begin
      r_ds_bus <= i_ds_to_es_bus;
    end
  end

  // Once an excepting instruction moves to ms, block requests until the flush
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_exc_block <= 1'b0;
    end else if (i_flush) begin
      r_exc_block <= 1'b0;
    end else if (o_es_to_ms_valid && i_ms_allowin && w_es_is_exc) begin
      r_exc_block <= 1'b1;
    end
  end

  // Store byte lanes and data replication; loads never drive byte enables
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = w_ds.rkd;
    case (w_ds.mem_size)
      SIZE_BYTE: begin
        w_wstrb = 4'b0001 << w_alu_result[1:0];
        w_wdata = {4{w_ds.rkd[7:0]}};
      end
      SIZE_HALF: begin
        w_wstrb = 4'b0011 << {w_alu_result[1], 1'b0};
        w_wdata = {2{w_ds.rkd[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = w_ds.rkd;
      end
    endcase
    if (!w_ds.mem_we) begin
      w_wstrb = 4'b0000;
    end
  end

  assign o_data_sram_wr    = w_ds.mem_we;
  assign o_data_sram_size  = w_ds.mem_size;
  assign o_data_sram_addr  = w_alu_result;
  assign o_data_sram_wstrb = w_wstrb;
  assign o_data_sram_wdata = w_wdata;

  // Forward results to ms; an exception from ID is passed untouched, ALE only fills in otherwise
  always_comb begin
    w_ms_bus              = '0;
    w_ms_bus.st_or_ld     = w_ds.st_or_ld;
    w_ms_bus.mem_we       = w_ds.mem_we;
    w_ms_bus.mem_size     = w_ds.mem_size;
    w_ms_bus.ld_unsigned  = w_ds.ld_unsigned;
    w_ms_bus.res_from_mem = w_ds.res_from_mem;
    w_ms_bus.gr_we        = w_ds.gr_we;
    w_ms_bus.dest         = w_ds.dest;
    w_ms_bus.alu_result   = w_alu_result;
    w_ms_bus.pc           = w_ds.pc;
    w_ms_bus.csr_we       = w_ds.csr_we;
    w_ms_bus.csr_num      = w_ds.csr_num;
    w_ms_bus.csr_wdata    = w_ds.csr_wdata;
    w_ms_bus.ertn         = w_ds.ertn;
    w_ms_bus.is_exc       = w_es_is_exc;
    w_ms_bus.ecode        = w_ds.ecode;
    w_ms_bus.esubcode     = w_ds.esubcode;
    w_ms_bus.addr_exc     = w_ds.addr_exc;
    w_ms_bus.badv         = w_ds.badv;
    w_ms_bus.pc_to_era    = w_ds.pc;
    w_ms_bus.is_tlb_exc   = w_ds.is_tlb_exc;
    if (!w_ds.is_exc && w_ale) begin
      w_ms_bus.ecode    = ECODE_ALE;
      w_ms_bus.esubcode = 9'h000;
      w_ms_bus.addr_exc = 1'b1;
      w_ms_bus.badv     = w_alu_result;
    end
  end

  assign o_es_to_ms_bus    = w_ms_bus;
  assign o_es_to_ds_dest   = w_ds.dest & {5{r_es_valid && w_ds.gr_we}};
  assign o_es_to_ds_result = w_alu_result;
  assign o_es_to_ds_is_ld  = r_es_valid && w_ds.res_from_mem;

endmodule
